// File: rtl/nec_key_decoder_if.sv
// rtl/nec_key_decoder_if.sv - NEC receiver to key decoder frame/repeat link
interface nec_key_decoder_if;
  logic [31:0] frame;
  logic        frame_vld;
  logic        rpt;

  modport master (output frame, frame_vld, rpt);
  modport slave  (input  frame, frame_vld, rpt);
endinterface

// File: rtl/nec_key_decoder.sv
// rtl/nec_key_decoder.sv - NEC frame validation and press/auto-repeat/release events
module nec_key_decoder #(
  parameter int          CLK_DIV    = 50,
  parameter int          TIMEOUT_MS = 120,
  parameter int          REP_DELAY  = 3,
  parameter int          REP_RATE   = 2,
  parameter int          ADDR_CHECK = 0,
  parameter logic [7:0]  ADDR       = 8'h00
) (
  input  logic                clk,
  input  logic                rst,
  nec_key_decoder_if.slave    i_rx,
  output logic [7:0]          o_key,
  output logic [7:0]          o_addr,
  output logic                o_key_vld,
  output logic                o_key_rpt,
  output logic                o_key_hold,
  output logic                o_key_rel,
  output logic [7:0]          o_err_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;

  localparam int PRE_N = CLK_DIV * 1000;
  localparam int PW    = $clog2(PRE_N);
  localparam int MW    = $clog2(TIMEOUT_MS + 1);

  localparam logic [PW-1:0] PRE_MAX = PW'(PRE_N - 1);
  localparam logic [MW-1:0] MS_LAST = MW'(TIMEOUT_MS - 1);
  localparam logic [7:0]    DELAY   = 8'(REP_DELAY);
  localparam logic [7:0]    RATE    = 8'(REP_RATE);

  logic [1:0]    r_state;
  logic          r_ret_held;
  logic [31:0]   r_frame;
  logic [PW-1:0] r_pre;
  logic [MW-1:0] r_ms;
  logic [7:0]    r_rep_cnt;
  logic [7:0]    r_rate_cnt;

  logic [7:0] w_addr, w_cmd, w_rep_n, w_rate_n;
  logic       w_valid, w_tick, w_timer_run;

  assign w_addr      = r_frame[31:24];
  assign w_cmd       = r_frame[15:8];
  assign w_valid     = (w_addr == ~r_frame[23:16]) && (w_cmd == ~r_frame[7:0]) &&
                       ((ADDR_CHECK == 0) || (w_addr == ADDR));
  assign w_tick      = (r_pre == PRE_MAX);
  // An invalid frame seen while held must not stall the release timer.
  assign w_timer_run = (r_state == S_HELD) || ((r_state == S_CHECK) && r_ret_held);
  assign w_rep_n     = (r_rep_cnt == 8'hFF) ? 8'hFF : r_rep_cnt + 8'd1;
  assign w_rate_n    = r_rate_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ret_held <= 1'b0;
      r_frame    <= '0;
      r_pre      <= '0;
      r_ms       <= '0;
      r_rep_cnt  <= '0;
      r_rate_cnt <= '0;
      o_key      <= '0;
      o_addr     <= '0;
      o_key_vld  <= 1'b0;
      o_key_rpt  <= 1'b0;
      o_key_hold <= 1'b0;
      o_key_rel  <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      o_key_vld <= 1'b0;
      o_key_rpt <= 1'b0;
      o_key_rel <= 1'b0;

      if (i_rx.frame_vld)
        r_frame <= i_rx.frame;

      if (w_timer_run) begin
        if (w_tick) begin
          r_pre <= '0;
          if (r_ms != MS_LAST)
            r_ms <= r_ms + 1'b1;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (i_rx.frame_vld) begin
            r_state    <= S_CHECK;
            r_ret_held <= 1'b0;
          end
        end

        S_CHECK: begin
          if (w_valid) begin
            o_key_vld  <= 1'b1;
            o_key      <= w_cmd;
            o_addr     <= w_addr;
            o_key_hold <= 1'b1;
            r_rep_cnt  <= '0;
            r_rate_cnt <= '0;
            r_pre      <= '0;
            r_ms       <= '0;
          end else if (o_err_cnt != 8'hFF) begin
            o_err_cnt <= o_err_cnt + 8'd1;
          end
          // A frame landing here is judged next cycle; remember where we'd return.
          if (i_rx.frame_vld) begin
            r_state <= S_CHECK;
            if (w_valid)
              r_ret_held <= 1'b1;
          end else if (w_valid || r_ret_held) begin
            r_state <= S_HELD;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_HELD: begin
          if (i_rx.frame_vld) begin
            r_state    <= S_CHECK;
            r_ret_held <= 1'b1;
          end else if (i_rx.rpt) begin
            r_pre     <= '0;
            r_ms      <= '0;
            r_rep_cnt <= w_rep_n;
            if (w_rep_n == DELAY) begin
              o_key_vld  <= 1'b1;
              o_key_rpt  <= 1'b1;
              r_rate_cnt <= '0;
            end else if (w_rep_n > DELAY) begin
              if (w_rate_n >= RATE) begin
                o_key_vld  <= 1'b1;
                o_key_rpt  <= 1'b1;
                r_rate_cnt <= '0;
              end else begin
                r_rate_cnt <= w_rate_n;
              end
            end
          end else if (w_tick && (r_ms == MS_LAST)) begin
            o_key_rel  <= 1'b1;
            o_key_hold <= 1'b0;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nec_key_decoder.md
Name: nec_key_decoder

Overview:
- Sits directly downstream of the NEC IR receiver and consumes its 32-bit frame output, frame-complete strobe and repeat-code strobe.
- Validates the address/command complement bytes and applies an optional address filter.
- Converts raw frames and repeat codes into clean key press, auto-repeat and release events for the display and application logic.

Parameters:
- CLK_DIV, 50: clk cycles per microsecond (50 MHz clk).
- TIMEOUT_MS, 120: ms without a repeat code before a held key is released.
- REP_DELAY, 3: repeat codes received before the first auto-repeat event.
- REP_RATE, 2: one auto-repeat event per REP_RATE repeat codes once past REP_DELAY (≥1).
- ADDR_CHECK, 0: 1 = reject frames whose address differs from ADDR.
- ADDR, 8'h00: expected address byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- i_frame  in  32  received frame: [31:24] addr, [23:16] ~addr, [15:8] cmd, [7:0] ~cmd.
- i_frame_vld  in  1  one-cycle pulse; i_frame is valid in that cycle.
- i_repeat  in  1  one-cycle pulse per NEC repeat code (9 ms / 2.25 ms leader).
- o_key  out  8  command byte of the last accepted frame.
- o_addr  out  8  address byte of the last accepted frame.
- o_key_vld  out  1  one-cycle key event pulse.
- o_key_rpt  out  1  qualifies o_key_vld: 0 = new press, 1 = auto-repeat.
- o_key_hold  out  1  level; high while a key is considered held.
- o_key_rel  out  1  one-cycle pulse on release by timeout.
- o_err_cnt  out  8  rejected-frame counter, saturates at 255.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, all counters 0.
- Frame capture: i_frame is registered whenever i_frame_vld=1, in any state.
- Frame check: runs in the CHECK state, which lasts one cycle.
  - Valid frame: addr==~inv_addr and cmd==~inv_cmd, and (ADDR_CHECK==0 or addr==ADDR).
- Latency, new press: i_frame_vld in cycle N → o_key_vld=1, o_key_rpt=0 in cycle N+2. o_key and o_addr update in the same cycle N+2.
- Latency, auto-repeat event: i_repeat in cycle N → o_key_vld=1, o_key_rpt=1 in cycle N+1.
- States:
  - IDLE: i_frame_vld → CHECK. i_repeat ignored.
  - CHECK, valid frame: emit press, clear rep_cnt/rate_cnt, clear ms timer and prescaler, set o_key_hold=1, go to HELD.
  - CHECK, invalid frame: o_err_cnt++ (saturating). Return to the state held before CHECK (IDLE or HELD), with HELD timer state preserved and still running.
  - CHECK, i_frame_vld arriving in the CHECK cycle: the new frame is captured and CHECK repeats next cycle. No frame is lost; the current result uses the old frame.
  - HELD, i_frame_vld: → CHECK. A valid frame is a new press, with no release pulse in between.
  - HELD, i_repeat: clear timer and prescaler. rep_cnt++ (saturates at 255). Once rep_cnt ≥ REP_DELAY, increment rate_cnt.
    - Event emitted on the repeat where rep_cnt first equals REP_DELAY, then on every REP_RATE-th repeat after that.
    - rate_cnt wraps to 0 on each event.
  - HELD, timeout: prescaler produces a 1 ms tick every CLK_DIV*1000 clks, and the ms counter increments on each tick. On the tick where the ms counter reaches TIMEOUT_MS-1: o_key_rel pulse, o_key_hold=0 in the same cycle, go to IDLE.
- Simultaneous events:
  - i_frame_vld and i_repeat in the same cycle: the frame wins and the repeat is dropped.
  - Timeout tick and i_repeat in the same cycle: the repeat wins and there is no release.
- Output hold: o_key and o_addr hold their last accepted values through release and IDLE. Invalid frames never change them.
- o_err_cnt: cleared only by rst.
- rst mid-HELD: immediate return to reset values. No release pulse.

Test Plan:
- Valid press: i_frame=32'h00FF_45BA pulse → 2 cycles later o_key_vld=1, o_key_rpt=0, o_key=8'h45, o_addr=8'h00, o_key_hold=1.
- Invalid frame: i_frame=32'h00FF_4545 in IDLE → no o_key_vld, o_err_cnt=1, o_key unchanged. 256 such frames → o_err_cnt stays 255.
- Auto-repeat: after a valid press, 8 i_repeat pulses at 108 ms spacing (REP_DELAY=3, REP_RATE=2) → rpt events on the 3rd, 5th and 7th repeats only. o_key_hold stays 1.
- Timeout: valid press, then no repeats → o_key_rel pulse and o_key_hold=0 exactly 120 ms (±1 tick) after CHECK. o_key remains 8'h45.
- Address filter: ADDR_CHECK=1, ADDR=8'h04; i_frame=32'h00FF_45BA → rejected, err +1. i_frame=32'h04FB_16E9 → press with o_key=8'h16.
- Collisions: i_frame_vld with i_repeat in the same HELD cycle → only a new press (rpt=0), rep_cnt cleared. Back-to-back i_frame_vld in CHECK → two press events 1 cycle apart. rst asserted mid-HELD → all outputs 0 asynchronously, no o_key_rel.
